// File: rtl/adc_fifo_packer.sv
// adc_fifo_packer: frames ADC sample beats into header-led 128-bit packets, admitting only whole packets
module adc_fifo_packer #(
  parameter int DATA_WD = 128,
  parameter int SAMPLE_WD = 64,
  parameter int HEAD_WD = 64,
  parameter logic [HEAD_WD-1:0] HEAD_MAGIC = 64'h55AA_A55A_5AA5_AA55,
  parameter int PKT_BEATS = 256,
  parameter int ADC_CNT_WD = 11,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_MARGIN = 8
) (
  input  logic                  adc_clk,
  input  logic                  rst,
  input  logic                  adc_enable,
  input  logic                  adc_valid,
  input  logic [SAMPLE_WD-1:0]  adc_data,
  input  logic [ADC_CNT_WD-1:0] fifo_wr_cnt,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [DATA_WD-1:0]    fifo_dout,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  ovf_err,
  output logic                  busy
);
  localparam int WW = $clog2(PKT_BEATS + 1);
  localparam int SW = $clog2(2 * PKT_BEATS + 1);
  localparam logic [ADC_CNT_WD:0] NEED = (ADC_CNT_WD + 1)'(PKT_BEATS + 1 + CNT_MARGIN);
  typedef enum logic [2:0] {IDLE, WAIT_SOP, PAYLOAD, DISCARD, PAD} state_t;
  state_t state_q, state_d;
  logic [31:0] seq_q, seq_d;
  logic [SAMPLE_WD-1:0] half_q, half_d;
  logic half_vld_q, half_vld_d;
  logic [WW-1:0] word_q, word_d;
  logic [SW-1:0] samp_q, samp_d;
  logic wr_q, wr_d;
  logic [DATA_WD-1:0] dout_q, dout_d;
  logic [15:0] pkt_q, pkt_d, drop_q, drop_d;
  logic ovf_q, ovf_d, busy_q, busy_d;
  logic [ADC_CNT_WD:0] free_space;
  logic admit, last_word, last_samp;
  assign free_space = (ADC_CNT_WD + 1)'(FIFO_DEPTH) - {1'b0, fifo_wr_cnt};
  assign admit = free_space >= NEED;
  assign last_word = word_q == WW'(PKT_BEATS - 1);
  assign last_samp = samp_q == SW'(2 * PKT_BEATS - 1);
  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    half_d = half_q;
    half_vld_d = half_vld_q;
    word_d = word_q;
    samp_d = samp_q;
    wr_d = 1'b0;
    dout_d = '0;
    pkt_d = pkt_q;
    drop_d = drop_q;
    ovf_d = ovf_q | (wr_q & fifo_full);
    case (state_q)
      IDLE: state_d = adc_enable ? WAIT_SOP : IDLE;
      WAIT_SOP:
        if (!adc_enable) state_d = IDLE;
        else if (adc_valid) begin
          seq_d = seq_q + 32'd1;
          if (admit) begin
            wr_d = 1'b1;
            dout_d = {HEAD_MAGIC, seq_q, 32'(PKT_BEATS)};
            half_d = adc_data;
            half_vld_d = 1'b1;
            word_d = '0;
            pkt_d = pkt_q + 16'd1;
            state_d = PAYLOAD;
          end else begin
            samp_d = SW'(1);
            drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
            state_d = DISCARD;
          end
        end
      PAYLOAD:
        if (!adc_enable) state_d = PAD;
        else if (adc_valid) begin
          half_vld_d = !half_vld_q;
          half_d = half_vld_q ? half_q : adc_data;
          if (half_vld_q) begin
            wr_d = 1'b1;
            dout_d = {half_q, adc_data};
            word_d = word_q + WW'(1);
            state_d = last_word ? WAIT_SOP : PAYLOAD;
          end
        end
      DISCARD:
        if (!adc_enable) state_d = IDLE;
        else if (adc_valid) begin
          samp_d = samp_q + SW'(1);
          state_d = last_samp ? WAIT_SOP : DISCARD;
        end
      PAD: begin
        wr_d = 1'b1;
        dout_d = half_vld_q ? {half_q, {SAMPLE_WD{1'b0}}} : '0;
        half_vld_d = 1'b0;
        word_d = word_q + WW'(1);
        state_d = last_word ? IDLE : PAD;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {PAYLOAD, DISCARD, PAD};
  end
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_q <= IDLE;
      seq_q <= '0;
      half_q <= '0;
      half_vld_q <= 1'b0;
      word_q <= '0;
      samp_q <= '0;
      wr_q <= 1'b0;
      dout_q <= '0;
      pkt_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      half_q <= half_d;
      half_vld_q <= half_vld_d;
      word_q <= word_d;
      samp_q <= samp_d;
      wr_q <= wr_d;
      dout_q <= dout_d;
      pkt_q <= pkt_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
    end
  end
  assign fifo_wr = wr_q;
  assign fifo_dout = dout_q;
  assign pkt_cnt = pkt_q;
  assign drop_cnt = drop_q;
  assign ovf_err = ovf_q;
  assign busy = busy_q;
endmodule
